// File: rtl/exmem_reg.sv
// EX/MEM pipeline register: captures one execute-stage result per cycle and turns it into a bubble on
// flush, on a flush left pending from a stall, or once a halt has retired. Counts retired instructions.
module exmem_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] instr_in,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] set_in,
    input  logic [15:0] btr_in,
    input  logic [15:0] pc_plus2_in,
    input  logic [15:0] store_data_in,
    input  logic        RegWriteEN_in,
    input  logic [2:0]  DstRegNum_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic [1:0]  ResultSel_in,
    input  logic        Halt_in,
    input  logic        stall,
    input  logic        flush,
    output logic        EXMEM_Valid,
    output logic [15:0] EXMEM_Instr,
    output logic [15:0] EXMEM_Addr,
    output logic [15:0] EXMEM_StoreData,
    output logic        EXMEM_MemWrite,
    output logic        EXMEM_MemRead,
    output logic        EXMEM_RegWriteEN,
    output logic [2:0]  EXMEM_DstRegNum,
    output logic        EXMEM_Halt,
    output logic [15:0] EXMEM_DATA,
    output logic        halted,
    output logic [15:0] retire_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic        pflush_q, pflush_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] alu_q, alu_d;
    logic [15:0] set_q, set_d;
    logic [15:0] btr_q, btr_d;
    logic [15:0] pc2_q, pc2_d;
    logic [15:0] store_q, store_d;
    logic        memwr_q, memwr_d;
    logic        memrd_q, memrd_d;
    logic        regwr_q, regwr_d;
    logic [2:0]  dst_q, dst_d;
    logic        halt_q, halt_d;
    logic [1:0]  rsel_q, rsel_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bubble;

    assign bubble = !valid_in || flush || pflush_q || (state_q == HALTED);

    always_comb begin
        state_d  = state_q;
        pflush_d = pflush_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        alu_d    = alu_q;
        set_d    = set_q;
        btr_d    = btr_q;
        pc2_d    = pc2_q;
        store_d  = store_q;
        memwr_d  = memwr_q;
        memrd_d  = memrd_q;
        regwr_d  = regwr_q;
        dst_d    = dst_q;
        halt_d   = halt_q;
        rsel_d   = rsel_q;
        cnt_d    = cnt_q;
        if (stall) begin
            // a flush seen while held must still kill the next captured instruction
            pflush_d = pflush_q | flush;
        end else begin
            pflush_d = 1'b0;
            if (bubble) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                alu_d   = 16'h0000;
                set_d   = 16'h0000;
                btr_d   = 16'h0000;
                pc2_d   = 16'h0000;
                store_d = 16'h0000;
                memwr_d = 1'b0;
                memrd_d = 1'b0;
                regwr_d = 1'b0;
                dst_d   = 3'd0;
                halt_d  = 1'b0;
                rsel_d  = 2'b00;
            end else begin
                valid_d = 1'b1;
                instr_d = instr_in;
                alu_d   = alu_out_in;
                set_d   = set_in;
                btr_d   = btr_in;
                pc2_d   = pc_plus2_in;
                store_d = store_data_in;
                memwr_d = MemWrite_in;
                memrd_d = MemRead_in;
                regwr_d = RegWriteEN_in;
                dst_d   = DstRegNum_in;
                halt_d  = Halt_in;
                rsel_d  = ResultSel_in;
                cnt_d   = cnt_q + 16'd1;
                if (Halt_in) state_d = HALTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pflush_q <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            alu_q    <= 16'h0000;
            set_q    <= 16'h0000;
            btr_q    <= 16'h0000;
            pc2_q    <= 16'h0000;
            store_q  <= 16'h0000;
            memwr_q  <= 1'b0;
            memrd_q  <= 1'b0;
            regwr_q  <= 1'b0;
            dst_q    <= 3'd0;
            halt_q   <= 1'b0;
            rsel_q   <= 2'b00;
            cnt_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pflush_q <= pflush_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            alu_q    <= alu_d;
            set_q    <= set_d;
            btr_q    <= btr_d;
            pc2_q    <= pc2_d;
            store_q  <= store_d;
            memwr_q  <= memwr_d;
            memrd_q  <= memrd_d;
            regwr_q  <= regwr_d;
            dst_q    <= dst_d;
            halt_q   <= halt_d;
            rsel_q   <= rsel_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        EXMEM_DATA = 16'h0000;
        if (valid_q) begin
            case (rsel_q)
                2'b00:   EXMEM_DATA = alu_q;
                2'b01:   EXMEM_DATA = set_q;
                2'b10:   EXMEM_DATA = btr_q;
                default: EXMEM_DATA = pc2_q;
            endcase
        end
    end

    assign EXMEM_Valid      = valid_q;
    assign EXMEM_Instr      = instr_q;
    assign EXMEM_Addr       = alu_q;
    assign EXMEM_StoreData  = store_q;
    assign EXMEM_MemWrite   = memwr_q;
    assign EXMEM_MemRead    = memrd_q;
    assign EXMEM_RegWriteEN = regwr_q;
    assign EXMEM_DstRegNum  = dst_q;
    assign EXMEM_Halt       = halt_q;
    assign halted           = (state_q == HALTED);
    assign retire_cnt       = cnt_q;

endmodule

// File: tb/tb_exmem_reg.sv
// Scoreboard bench for exmem_reg: a behavioural model predicts each cycle's outputs into a queue,
// and each scenario task pops and compares them after the capturing edge.
module tb_exmem_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] instr_in = '0, alu_out_in = '0, set_in = '0, btr_in = '0;
    logic [15:0] pc_plus2_in = '0, store_data_in = '0;
    logic        RegWriteEN_in = 1'b0;
    logic [2:0]  DstRegNum_in = '0;
    logic        MemWrite_in = 1'b0, MemRead_in = 1'b0;
    logic [1:0]  ResultSel_in = '0;
    logic        Halt_in = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        EXMEM_Valid, EXMEM_MemWrite, EXMEM_MemRead, EXMEM_RegWriteEN, EXMEM_Halt, halted;
    logic [15:0] EXMEM_Instr, EXMEM_Addr, EXMEM_StoreData, EXMEM_DATA, retire_cnt;
    logic [2:0]  EXMEM_DstRegNum;

    exmem_reg #(.NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .instr_in(instr_in), .alu_out_in(alu_out_in),
        .set_in(set_in), .btr_in(btr_in), .pc_plus2_in(pc_plus2_in), .store_data_in(store_data_in),
        .RegWriteEN_in(RegWriteEN_in), .DstRegNum_in(DstRegNum_in), .MemWrite_in(MemWrite_in),
        .MemRead_in(MemRead_in), .ResultSel_in(ResultSel_in), .Halt_in(Halt_in), .stall(stall),
        .flush(flush), .EXMEM_Valid(EXMEM_Valid), .EXMEM_Instr(EXMEM_Instr), .EXMEM_Addr(EXMEM_Addr),
        .EXMEM_StoreData(EXMEM_StoreData), .EXMEM_MemWrite(EXMEM_MemWrite),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_RegWriteEN(EXMEM_RegWriteEN),
        .EXMEM_DstRegNum(EXMEM_DstRegNum), .EXMEM_Halt(EXMEM_Halt), .EXMEM_DATA(EXMEM_DATA),
        .halted(halted), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr, addr, store;
        logic        memwr, memrd, regwr;
        logic [2:0]  dst;
        logic        halt;
        logic [15:0] data;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr, alu, set, btr, pc2, sd;
        logic        regwr;
        logic [2:0]  dst;
        logic        memwr, memrd;
        logic [1:0]  rs;
        logic        halt, stall, flush;
    } in_t;

    exp_t        sb[$];
    exp_t        m_prev;
    logic        m_halted, m_pflush;
    logic [15:0] m_cnt;
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t bubble_val(input logic [15:0] cnt, input logic h);
        exp_t e;
        e = '0;
        e.instr  = 16'h0800;
        e.cnt    = cnt;
        e.halted = h;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.valid = EXMEM_Valid;      s.instr = EXMEM_Instr;     s.addr = EXMEM_Addr;
        s.store = EXMEM_StoreData;  s.memwr = EXMEM_MemWrite;  s.memrd = EXMEM_MemRead;
        s.regwr = EXMEM_RegWriteEN; s.dst = EXMEM_DstRegNum;   s.halt = EXMEM_Halt;
        s.data = EXMEM_DATA;        s.halted = halted;         s.cnt = retire_cnt;
        return s;
    endfunction

    task automatic model_reset();
        m_halted = 1'b0;
        m_pflush = 1'b0;
        m_cnt    = 16'h0000;
        m_prev   = bubble_val(16'h0000, 1'b0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // drive one cycle, predict its result, push, and advance past the capturing edge
    task automatic step(input in_t t);
        exp_t w;
        valid_in = t.valid; instr_in = t.instr; alu_out_in = t.alu; set_in = t.set; btr_in = t.btr;
        pc_plus2_in = t.pc2; store_data_in = t.sd; RegWriteEN_in = t.regwr; DstRegNum_in = t.dst;
        MemWrite_in = t.memwr; MemRead_in = t.memrd; ResultSel_in = t.rs; Halt_in = t.halt;
        stall = t.stall; flush = t.flush;
        if (t.stall) begin
            m_pflush = m_pflush | t.flush;
            w = m_prev;
        end else if (!t.valid || t.flush || m_pflush || m_halted) begin
            m_pflush = 1'b0;
            w = bubble_val(m_cnt, m_halted);
        end else begin
            m_pflush = 1'b0;
            m_cnt = m_cnt + 16'd1;
            if (t.halt) m_halted = 1'b1;
            w.valid = 1'b1; w.instr = t.instr; w.addr = t.alu; w.store = t.sd;
            w.memwr = t.memwr; w.memrd = t.memrd; w.regwr = t.regwr; w.dst = t.dst; w.halt = t.halt;
            w.data = (t.rs == 2'b00) ? t.alu : (t.rs == 2'b01) ? t.set : (t.rs == 2'b10) ? t.btr : t.pc2;
            w.cnt = m_cnt;
            w.halted = m_halted;
        end
        m_prev = w;
        sb.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got;
        model_reset();
        #7;
        got = sample();
        checks++;
        if (got !== bubble_val(16'h0000, 1'b0)) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", got, bubble_val(16'h0000, 1'b0));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        exp_t got, want;
        step('{1'b1, 16'h4321, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        got = sample(); want = sb.pop_front();
        checks++;
        if (got !== want) begin errors++; $display("FAIL add got=%h want=%h", got, want); end
        checks++;
        if ({got.valid, got.regwr, got.dst, got.data, got.cnt} !== {1'b1, 1'b1, 3'd3, 16'h1234, 16'd1}) begin
            errors++;
            $display("FAIL add_fields got data=%h cnt=%h dst=%0d want data=1234 cnt=1 dst=3", got.data, got.cnt, got.dst);
        end
    endtask

    task automatic test_result_sel();
        in_t  tbl[6];
        exp_t got, want;
        tbl[0] = '{1'b1, 16'h1111, 16'hA0A0, 16'h0001, 16'hB0B0, 16'hC0C0, 16'h5555, 1'b1, 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'h2222, 16'hA1A1, 16'h0000, 16'hB1B1, 16'hC1C1, 16'h6666, 1'b1, 3'd2, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 16'h3333, 16'hA2A2, 16'h0001, 16'hB2B2, 16'hC2C2, 16'h7777, 1'b1, 3'd5, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'h4444, 16'hA3A3, 16'h0001, 16'hB3B3, 16'hC3C3, 16'h8888, 1'b0, 3'd7, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h5555, 16'hA4A4, 16'h0001, 16'hB4B4, 16'hC4C4, 16'h9999, 1'b1, 3'd6, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 16'h6666, 16'hA5A5, 16'h0001, 16'hB5B5, 16'hC5C5, 16'hAAAA, 1'b1, 3'd4, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i]);
            got = sample(); want = sb.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL result_sel[%0d] got=%h want=%h", i, got, want); end
        end
    endtask

    task automatic test_stall();
        exp_t got, want;
        logic [15:0] cnt0;
        step('{1'b1, 16'h7000, 16'hDEAD, 16'h0001, 16'hBEEF, 16'h0102, 16'h0, 1'b1, 3'd4, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0});
        got = sample(); want = sb.pop_front(); cnt0 = got.cnt;
        checks++;
        if (got !== want) begin errors++; $display("FAIL slt got=%h want=%h", got, want); end
        for (int i = 0; i < 3; i++) begin
            step('{1'b1, 16'h7100 + 16'(i), 16'h0F0F, 16'h0000, 16'h3333, 16'h4444, 16'h5555, 1'b1, 3'd2, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0});
            got = sample(); want = sb.pop_front();
            checks++;
            if (got !== want || got.data !== 16'h0001 || got.cnt !== cnt0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got=%h want=%h (data=0001)", i, got, want);
            end
        end
    endtask

    task automatic test_flush_stall();
        exp_t got, want;
        step('{1'b1, 16'h8000, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h00AA, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1});
        got = sample(); want = sb.pop_front();
        checks++;
        if (got !== want) begin errors++; $display("FAIL flush_in_stall got=%h want=%h", got, want); end
        step('{1'b1, 16'h8100, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h00BB, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        got = sample(); want = sb.pop_front();
        checks++;
        if (got !== want || {got.valid, got.memwr, got.instr} !== {1'b0, 1'b0, 16'h0800}) begin
            errors++;
            $display("FAIL pending_flush_bubble got=%h want=%h", got, want);
        end
        step('{1'b1, 16'h8200, 16'h0030, 16'h0, 16'h0, 16'h0, 16'h00CC, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        got = sample(); want = sb.pop_front();
        checks++;
        if (got !== want || got.valid !== 1'b1) begin errors++; $display("FAIL after_flush got=%h want=%h", got, want); end
    endtask

    task automatic test_halt();
        exp_t got, want;
        logic [15:0] cnt0;
        step('{1'b1, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0});
        got = sample(); want = sb.pop_front(); cnt0 = got.cnt;
        checks++;
        if (got !== want || {got.halt, got.halted, got.valid} !== 3'b111) begin
            errors++;
            $display("FAIL halt_capture got=%h want=%h", got, want);
        end
        for (int i = 0; i < 2; i++) begin
            step('{1'b1, 16'h9000, 16'h1357, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
            got = sample(); want = sb.pop_front();
            checks++;
            if (got !== want || got.valid !== 1'b0 || got.cnt !== cnt0) begin
                errors++;
                $display("FAIL halted_bubble[%0d] got=%h want=%h", i, got, want);
            end
        end
        do_reset();
        got = sample();
        checks++;
        if (got.halted !== 1'b0 || got.cnt !== 16'h0000) begin
            errors++;
            $display("FAIL halt_reset got halted=%b cnt=%h want halted=0 cnt=0000", got.halted, got.cnt);
        end
    endtask

    task automatic test_wrap();
        exp_t got, want;
        in_t  t;
        t = '{1'b1, 16'hA000, 16'h0042, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            step(t);
            want = sb.pop_front();
        end
        got = sample();
        checks++;
        if (got !== want || got.cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_ffff got=%h want=%h", got, want); end
        step(t);
        got = sample(); want = sb.pop_front();
        checks++;
        if (got !== want || got.cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got=%h want=%h", got, want); end
    endtask

    task automatic test_async_reset();
        exp_t got, want;
        step('{1'b1, 16'hB000, 16'h2468, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd6, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0});
        got = sample(); want = sb.pop_front();
        checks++;
        if (got !== want || got.valid !== 1'b1) begin errors++; $display("FAIL pre_async got=%h want=%h", got, want); end
        #1;
        rst = 1'b1;
        #1;
        got = sample();
        checks++;
        if (got !== bubble_val(16'h0000, 1'b0)) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", got, bubble_val(16'h0000, 1'b0));
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step('{1'b1, 16'hB100, 16'h1357, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        got = sample(); want = sb.pop_front();
        checks++;
        if (got !== want) begin errors++; $display("FAIL post_reset_capture got=%h want=%h", got, want); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_result_sel();
        test_stall();
        test_flush_stall();
        test_halt();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exmem_reg.md
EXMEM_REG -- requirements
Module: exmem_reg

Interface
REQ-001 SHALL have parameter: NOP_INSTR, 16'h0800, instruction word loaded on reset and on every bubble.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have inputs: valid_in 1, instr_in 16, alu_out_in 16, set_in 16, btr_in 16, pc_plus2_in 16, store_data_in 16 (forwarded read_data_2).
REQ-005 SHALL have control inputs: RegWriteEN_in 1, DstRegNum_in 3, MemWrite_in 1, MemRead_in 1, ResultSel_in 2, Halt_in 1.
REQ-006 SHALL have pipeline inputs: stall 1 (memory stage busy, hold), flush 1 (kill the instruction being captured).
REQ-007 SHALL have registered outputs: EXMEM_Valid 1, EXMEM_Instr 16, EXMEM_Addr 16 (captured alu_out), EXMEM_StoreData 16, EXMEM_MemWrite 1, EXMEM_MemRead 1, EXMEM_RegWriteEN 1, EXMEM_DstRegNum 3, EXMEM_Halt 1.
REQ-008 SHALL have outputs: EXMEM_DATA 16 (combinational forwarding/result value), halted 1, retire_cnt 16.

Function
REQ-009 SHALL, on rising clk with stall=0, capture one instruction per cycle; latency input-to-output exactly 1 cycle.
REQ-010 SHALL internally hold set, btr and pc_plus2 values alongside alu_out and ResultSel.
REQ-011 SHALL drive EXMEM_DATA from registered fields: ResultSel 00 alu_out, 01 set, 10 btr, 11 pc_plus2; forced 16'h0000 when EXMEM_Valid=0.
REQ-012 SHALL gate EXMEM_RegWriteEN, EXMEM_MemWrite, EXMEM_MemRead, EXMEM_Halt with valid: never 1 while EXMEM_Valid=0.
REQ-013 SHALL create a bubble when capturing with valid_in=0, flush=1, pending_flush=1, or state HALTED: Valid=0, all enables 0, DstRegNum 0, Instr NOP_INSTR, data fields 16'h0000.
REQ-014 SHALL, with stall=1, hold every registered output and retire_cnt unchanged.
REQ-015 SHALL, on flush=1 during stall=1, set internal pending_flush; the first capture with stall=0 is a bubble, then pending_flush clears.
REQ-016 SHALL treat flush=1 with stall=0 as an immediate bubble; pending_flush clears on that edge.
REQ-017 SHALL implement states RUN and HALTED; RUN->HALTED on an edge capturing a non-bubble with Halt_in=1 (that instruction itself is captured valid); HALTED exits only by reset.
REQ-018 SHALL assert halted=1 in HALTED; all captures in HALTED are bubbles regardless of valid_in.
REQ-019 SHALL increment retire_cnt by 1 on every edge capturing a non-bubble; wraps 16'hFFFF->16'h0000.
REQ-020 SHALL give stall priority over flush, and flush priority over valid_in.

Reset
REQ-021 SHALL, on rst=1 asynchronously and independent of clk: Valid 0, all enables 0, Halt 0, DstRegNum 0, Instr NOP_INSTR, data fields 0, EXMEM_DATA 0, state RUN, halted 0, pending_flush 0, retire_cnt 0.
REQ-022 SHALL resume capture on the first rising edge after rst deasserts; rst mid-stall or mid-HALTED discards all state.

Verification
REQ-023 SHALL pass: valid ADD, alu_out 16'h1234, RegWriteEN 1, Dst 3, ResultSel 00 -> next cycle Valid 1, RegWriteEN 1, DstRegNum 3, EXMEM_DATA 16'h1234, retire_cnt 1.
REQ-024 SHALL pass: captured SLT with set_in 16'h0001, ResultSel 01, then stall=1 for 3 cycles with new inputs -> outputs stay EXMEM_DATA 16'h0001, retire_cnt unchanged for 3 cycles.
REQ-025 SHALL pass: stall=1 plus flush=1 for one cycle, then stall=0 with valid store (MemWrite 1) -> captured Valid 0, MemWrite 0, Instr 16'h0800; the following valid instruction captures normally.
REQ-026 SHALL pass: valid HALT captured -> EXMEM_Halt 1, halted 1; next 2 valid inputs -> Valid 0, retire_cnt frozen; rst pulse -> halted 0, retire_cnt 0.
REQ-027 SHALL pass: retire_cnt preloaded to 16'hFFFF via 65535 valid captures -> next valid capture yields 16'h0000.
REQ-028 SHALL pass: rst asserted between clock edges while Valid 1 -> Valid and RegWriteEN drop to 0 before next edge.
